// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg: register offsets shared by gpio_in_capture and its bench
package gpio_in_pkg;
  localparam logic [3:0] ADDR_DATA    = 4'h0;
  localparam logic [3:0] ADDR_RISE_EN = 4'h4;
  localparam logic [3:0] ADDR_FALL_EN = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'hC;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: 2-flop synchronizer plus optional debounce for one pin
// Debounce counter exists only when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_stable
);
  logic r_s1, r_s2, r_stable;
  always_ff @(posedge clk) begin
    r_s1 <= rst ? 1'b0 : i_pin;
    r_s2 <= rst ? 1'b0 : r_s1;
  end
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  logic w_done;
  assign w_done = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (r_s2 == r_stable) begin
      r_cnt <= '0;
    end else if (w_done) begin
      r_stable <= r_s2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  always_ff @(posedge clk) r_stable <= rst ? 1'b0 : r_s2;
`endif
  assign o_stable = r_stable;
endmodule

// File: rtl/gpio_in_capture.sv
// gpio_in_capture: debounced GPIO input capture with edge STATUS and IRQ
// Define GPIO_IN_DEBOUNCE_EN to enable per-pin debounce counters.
module gpio_in_capture
  import gpio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] GPIO_IN,
  input  logic             BUS_WE,
  input  logic             BUS_RE,
  input  logic [3:0]       BUS_ADDR,
  input  logic [31:0]      BUS_WDATA,
  output logic [31:0]      BUS_RDATA,
  output logic             BUS_RVALID,
  output logic             IRQ
);
  logic [WIDTH-1:0] w_stable, w_set, w_clr;
  logic [WIDTH-1:0] r_stable_d, r_rise_en, r_fall_en, r_status;
  logic [3:0]       w_addr;
  logic [31:0]      w_rd, r_rdata;
  logic             r_rvalid, r_irq, w_unused;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (CLK),
      .rst     (RST),
      .i_pin   (GPIO_IN[i]),
      .o_stable(w_stable[i])
    );
  end
  assign w_addr   = {BUS_ADDR[3:2], 2'b00};
  assign w_unused = ^{BUS_ADDR[1:0], BUS_WDATA};
  assign w_set = (w_stable & ~r_stable_d & r_rise_en) | (~w_stable & r_stable_d & r_fall_en);
  assign w_clr = (BUS_WE && w_addr == ADDR_STATUS) ? BUS_WDATA[WIDTH-1:0] : '0;
  assign w_rd  = w_addr == ADDR_DATA    ? 32'(w_stable)  :
                 w_addr == ADDR_RISE_EN ? 32'(r_rise_en) :
                 w_addr == ADDR_FALL_EN ? 32'(r_fall_en) :
                 w_addr == ADDR_STATUS  ? 32'(r_status)  : '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stable_d <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_status   <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_stable_d <= w_stable;
      if (BUS_WE && w_addr == ADDR_RISE_EN) r_rise_en <= BUS_WDATA[WIDTH-1:0];
      if (BUS_WE && w_addr == ADDR_FALL_EN) r_fall_en <= BUS_WDATA[WIDTH-1:0];
      // a new edge wins over a same-cycle W1C
      r_status <= (r_status & ~w_clr) | w_set;
      if (BUS_RE) r_rdata <= w_rd;
      r_rvalid <= BUS_RE;
      r_irq    <= |r_status;
    end
  end
  assign BUS_RDATA  = r_rdata;
  assign BUS_RVALID = r_rvalid;
  assign IRQ        = r_irq;
endmodule

// File: tb/tb_gpio_in_capture.sv
// tb_gpio_in_capture: directed bench with a behavioural register/pin model
module tb_gpio_in_capture;
  import gpio_in_pkg::*;
  localparam int W  = 4;
  localparam int DB = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 3;
`endif
  logic clk = 0, rst = 1, we = 0, re = 0;
  logic [W-1:0] gpio = '0;
  logic [3:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic rvalid, irq;
  gpio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK(clk), .RST(rst), .GPIO_IN(gpio), .BUS_WE(we), .BUS_RE(re),
    .BUS_ADDR(addr), .BUS_WDATA(wdata), .BUS_RDATA(rdata),
    .BUS_RVALID(rvalid), .IRQ(irq)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_fail = 0;
  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [W-1:0] m_stable, m_prev, m_rise, m_fall, m_status, m_set, m_clr, m_sync;
  logic [W-1:0] hist [2];
  int run [W];
  logic [31:0] m_rdata;
  logic m_rvalid, m_irq;
  bit live = 0;
  function automatic logic [31:0] regval(logic [3:0] a);
    case (a[3:2])
      2'd0: return 32'(m_stable);
      2'd1: return 32'(m_rise);
      2'd2: return 32'(m_fall);
      default: return 32'(m_status);
    endcase
  endfunction
  // Model: pins reach the stable view two edges late, and a level is
  // accepted only after DB consecutive differing synchronized samples.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      {m_stable, m_prev, m_rise, m_fall, m_status} = '0;
      hist[0] = '0; hist[1] = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
      m_rdata = '0; m_rvalid = 0; m_irq = 0;
      live = 1;
    end else begin
      if (re) m_rdata = regval(addr);
      m_rvalid = re;
      m_irq    = m_status != 0;
      m_set = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
      m_clr = (we && addr[3:2] == 2'd3) ? wdata[W-1:0] : '0;
      m_status = (m_status & ~m_clr) | m_set;
      if (we && addr[3:2] == 2'd1) m_rise = wdata[W-1:0];
      if (we && addr[3:2] == 2'd2) m_fall = wdata[W-1:0];
      m_prev = m_stable;
      m_sync = hist[1];
      hist[1] = hist[0];
      hist[0] = gpio;
`ifdef GPIO_IN_DEBOUNCE_EN
      for (int i = 0; i < W; i++) begin
        run[i] = (m_sync[i] != m_stable[i]) ? run[i] + 1 : 0;
        if (run[i] == DB) begin
          m_stable[i] = m_sync[i];
          run[i] = 0;
        end
      end
`else
      m_stable = m_sync;
`endif
    end
    #1;
    if (live) begin
      cmp("model_rvalid", 32'(rvalid), 32'(m_rvalid));
      cmp("model_irq", 32'(irq), 32'(m_irq));
      cmp("model_rdata", rdata, m_rdata);
    end
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(logic [3:0] a, logic [31:0] d);
    addr = a; wdata = d; we = 1;
    tick();
    we = 0;
  endtask
  task automatic rd(string n, logic [3:0] a, logic [31:0] e);
    addr = a; re = 1;
    tick();
    re = 0;
    cmp({n, "_rvalid"}, 32'(rvalid), 32'd1);
    cmp(n, rdata, e);
  endtask
  initial begin
    repeat (3) tick();
    cmp("rst_rdata", rdata, 0);
    cmp("rst_rvalid", 32'(rvalid), 0);
    cmp("rst_irq", 32'(irq), 0);
    rst = 0;
    tick();
    cmp("idle_rvalid", 32'(rvalid), 0);
    rd("rst_rise_en", ADDR_RISE_EN, 0);
    addr = ADDR_DATA; re = 1; gpio = 4'h1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      cmp("data_early", rdata, 0);
    end
    tick();
    cmp("data_latency", rdata, 32'h1);
    re = 0;
    gpio = 4'h5;
    repeat (3) tick();
    gpio = 4'h1;
    repeat (LAT + 4) tick();
    rd("pulse_data", ADDR_DATA, 32'h1);
    rd("pulse_status", ADDR_STATUS, 0);
    cmp("pulse_irq", 32'(irq), 0);
    wr(ADDR_RISE_EN, 32'h1);
    gpio = 4'h0;
    repeat (LAT + 3) tick();
    gpio = 4'h1;
    repeat (LAT + 3) tick();
    rd("rise_status", ADDR_STATUS, 32'h1);
    cmp("rise_irq", 32'(irq), 1);
    wr(ADDR_STATUS, 32'h1);
    cmp("w1c_irq_lag", 32'(irq), 1);
    tick();
    cmp("w1c_irq_clear", 32'(irq), 0);
    rd("w1c_status", ADDR_STATUS, 0);
    wr(ADDR_FALL_EN, 32'h8);
    gpio = 4'h9;
    repeat (LAT + 3) tick();
    rd("rise3_no_status", ADDR_STATUS, 0);
    gpio = 4'h1;
    repeat (LAT) tick();
    wr(ADDR_STATUS, 32'h8);
    rd("fall_w1c_same_cycle", ADDR_STATUS, 32'h8);
    cmp("fall_irq", 32'(irq), 1);
    wr(ADDR_STATUS, 32'h8);
    tick();
    cmp("fall_irq_clear", 32'(irq), 0);
    wr(ADDR_DATA, 32'hF);
    rd("data_ro", ADDR_DATA, 32'h1);
    rd("addr_low_bits_ignored", 4'h5, 32'h1);
    addr = ADDR_RISE_EN; wdata = 32'h5; we = 1; re = 1;
    tick();
    we = 0; re = 0;
    cmp("rw_same_cycle_old", rdata, 32'h1);
    rd("rw_same_cycle_new", ADDR_RISE_EN, 32'h5);
    wr(ADDR_FALL_EN, 32'hF);
    gpio = 4'h3;
    repeat (2) tick();
    rst = 1;
    tick();
    rst = 0;
    cmp("midrst_irq", 32'(irq), 0);
    rd("midrst_data", ADDR_DATA, 0);
    rd("midrst_rise_en", ADDR_RISE_EN, 0);
    rd("midrst_fall_en", ADDR_FALL_EN, 0);
    rd("midrst_status", ADDR_STATUS, 0);
    repeat (LAT + 2) tick();
    rd("post_rst_data", ADDR_DATA, 32'h3);
    gpio = 4'hF;
    repeat (LAT + 2) tick();
    rd("all_high_data", ADDR_DATA, 32'hF);
    cmp("final_irq", 32'(irq), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
